// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM-stage data-memory access with stall/timeout FSM and the MEM/WB pipeline register.
module mem_wb_stage #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite_mem,
   input  logic [31:0] MemWriteData_mem,
   input  logic        MemToReg_mem,
   input  logic        RegWrite_mem,
   input  logic [4:0]  RegWriteAddr_mem,
   input  logic [31:0] ALUResult_mem,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic        stall_mem,
   output logic        RegWrite_wb,
   output logic [4:0]  RegWriteAddr_wb,
   output logic [31:0] RegWriteData_wb,
   output logic [1:0]  err_wb
);
   localparam int CW = $clog2(TIMEOUT) + 1;

   typedef enum logic {IDLE, WAIT} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] wait_cnt_q, wait_cnt_d;
   logic          regwrite_q, regwrite_d;
   logic [4:0]    addr_q, addr_d;
   logic [31:0]   data_q, data_d;
   logic [1:0]    err_q, err_d;
   logic          memop, misal, done, tmo;

   assign memop = MemWrite_mem | MemToReg_mem;
   assign misal = memop & (ALUResult_mem[1:0] != 2'b00);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         wait_cnt_q <= '0;
         regwrite_q <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         err_q      <= 2'b00;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         regwrite_q <= regwrite_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         err_q      <= err_d;
      end
   end

   // WAIT also falls back to IDLE if the request vanishes, so the FSM can never wedge
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      if (state_q == IDLE) begin
         if (dmem_req & ~dmem_ack) begin
            state_d    = WAIT;
            wait_cnt_d = CW'(1);
         end
      end else if (dmem_ack | tmo | ~dmem_req) begin
         state_d    = IDLE;
         wait_cnt_d = '0;
      end else begin
         wait_cnt_d = wait_cnt_q + 1'b1;
      end
   end

   always_comb begin
      dmem_req   = ~reset & memop & ~misal;
      dmem_we    = MemWrite_mem;
      dmem_addr  = ALUResult_mem;
      dmem_wdata = MemWriteData_mem;
      done       = dmem_req & dmem_ack;
      tmo        = (state_q == WAIT) & (wait_cnt_q == CW'(TIMEOUT - 1)) & ~dmem_ack;
      stall_mem  = dmem_req & ~dmem_ack & ~tmo;
   end

   // Bubbles clear RegWrite but hold addr/data; err is a one-cycle pulse
   always_comb begin
      regwrite_d = 1'b0;
      addr_d     = addr_q;
      data_d     = data_q;
      err_d      = 2'b00;
      if (!stall_mem) begin
         if (done) begin
            regwrite_d = RegWrite_mem;
            addr_d     = RegWriteAddr_mem;
            data_d     = MemToReg_mem ? dmem_rdata : ALUResult_mem;
         end else if (tmo) begin
            err_d = 2'b10;
         end else if (misal) begin
            err_d = 2'b01;
         end else if (!memop) begin
            regwrite_d = RegWrite_mem;
            addr_d     = RegWriteAddr_mem;
            data_d     = ALUResult_mem;
         end
      end
   end

   assign RegWrite_wb     = regwrite_q;
   assign RegWriteAddr_wb = addr_q;
   assign RegWriteData_wb = data_q;
   assign err_wb          = err_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed scenario tests for mem_wb_stage with hand-computed expectations.
module tb_mem_wb_stage;
   logic        clk = 1'b0;
   logic        reset;
   logic        MemWrite_mem, MemToReg_mem, RegWrite_mem, dmem_ack;
   logic [31:0] MemWriteData_mem, ALUResult_mem, dmem_rdata;
   logic [4:0]  RegWriteAddr_mem;
   logic        dmem_req, dmem_we, stall_mem, RegWrite_wb;
   logic [31:0] dmem_addr, dmem_wdata, RegWriteData_wb;
   logic [4:0]  RegWriteAddr_wb;
   logic [1:0]  err_wb;
   int          checks = 0;
   int          failures = 0;

   mem_wb_stage #(.TIMEOUT(16)) dut (
      .clk(clk), .reset(reset),
      .MemWrite_mem(MemWrite_mem), .MemWriteData_mem(MemWriteData_mem),
      .MemToReg_mem(MemToReg_mem), .RegWrite_mem(RegWrite_mem),
      .RegWriteAddr_mem(RegWriteAddr_mem), .ALUResult_mem(ALUResult_mem),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
      .stall_mem(stall_mem), .RegWrite_wb(RegWrite_wb),
      .RegWriteAddr_wb(RegWriteAddr_wb), .RegWriteData_wb(RegWriteData_wb),
      .err_wb(err_wb)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic mw, input logic mtr, input logic rw, input logic [4:0] ra,
                        input logic [31:0] alu, input logic [31:0] wd, input logic ack,
                        input logic [31:0] rd);
      MemWrite_mem = mw; MemToReg_mem = mtr; RegWrite_mem = rw; RegWriteAddr_mem = ra;
      ALUResult_mem = alu; MemWriteData_mem = wd; dmem_ack = ack; dmem_rdata = rd;
      #1;
   endtask

   task automatic test_reset_state;
      checks++; if (RegWrite_wb !== 1'b0) begin failures++; $display("FAIL por_regwrite got=%b exp=0", RegWrite_wb); end
      checks++; if (RegWriteAddr_wb !== 5'd0) begin failures++; $display("FAIL por_addr got=%0d exp=0", RegWriteAddr_wb); end
      checks++; if (RegWriteData_wb !== 32'd0) begin failures++; $display("FAIL por_data got=%h exp=0", RegWriteData_wb); end
      checks++; if (err_wb !== 2'b00) begin failures++; $display("FAIL por_err got=%b exp=00", err_wb); end
   endtask

   task automatic test_alu;
      drive(0, 0, 1, 5'd5, 32'h1234, 32'h0, 1'b1, 32'hBAD0BAD0);
      checks++; if (dmem_req !== 1'b0) begin failures++; $display("FAIL alu_req got=%b exp=0", dmem_req); end
      checks++; if (stall_mem !== 1'b0) begin failures++; $display("FAIL alu_stall got=%b exp=0", stall_mem); end
      tick;
      checks++; if (RegWrite_wb !== 1'b1) begin failures++; $display("FAIL alu_regwrite got=%b exp=1", RegWrite_wb); end
      checks++; if (RegWriteAddr_wb !== 5'd5) begin failures++; $display("FAIL alu_addr got=%0d exp=5", RegWriteAddr_wb); end
      checks++; if (RegWriteData_wb !== 32'h1234) begin failures++; $display("FAIL alu_data got=%h exp=00001234", RegWriteData_wb); end
      checks++; if (err_wb !== 2'b00) begin failures++; $display("FAIL alu_err got=%b exp=00", err_wb); end
   endtask

   task automatic test_load_zero_wait;
      drive(0, 1, 1, 5'd6, 32'h40, 32'h0, 1'b1, 32'hDEADBEEF);
      checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 32'h40) begin failures++; $display("FAIL ld_req got=%b/%b/%h exp=1/0/00000040", dmem_req, dmem_we, dmem_addr); end
      checks++; if (stall_mem !== 1'b0) begin failures++; $display("FAIL ld_stall got=%b exp=0", stall_mem); end
      tick;
      checks++; if (RegWriteData_wb !== 32'hDEADBEEF) begin failures++; $display("FAIL ld_data got=%h exp=deadbeef", RegWriteData_wb); end
      checks++; if (RegWrite_wb !== 1'b1 || RegWriteAddr_wb !== 5'd6) begin failures++; $display("FAIL ld_wb got=%b/%0d exp=1/6", RegWrite_wb, RegWriteAddr_wb); end
   endtask

   task automatic test_store_wait3;
      drive(1, 0, 0, 5'd3, 32'h80, 32'hCAFE, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         checks++; if (stall_mem !== 1'b1) begin failures++; $display("FAIL st_stall%0d got=%b exp=1", i, stall_mem); end
         checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin failures++; $display("FAIL st_req%0d got=%b/%b exp=1/1", i, dmem_req, dmem_we); end
         checks++; if (dmem_addr !== 32'h80 || dmem_wdata !== 32'hCAFE) begin failures++; $display("FAIL st_bus%0d got=%h/%h exp=00000080/0000cafe", i, dmem_addr, dmem_wdata); end
         tick;
         checks++; if (RegWrite_wb !== 1'b0 || err_wb !== 2'b00) begin failures++; $display("FAIL st_bubble%0d got=%b/%b exp=0/00", i, RegWrite_wb, err_wb); end
      end
      drive(1, 0, 0, 5'd3, 32'h80, 32'hCAFE, 1'b1, 32'h0);
      checks++; if (stall_mem !== 1'b0 || dmem_req !== 1'b1) begin failures++; $display("FAIL st_ack got=%b/%b exp=0/1", stall_mem, dmem_req); end
      tick;
      checks++; if (RegWriteData_wb !== 32'h80 || RegWriteAddr_wb !== 5'd3) begin failures++; $display("FAIL st_done got=%h/%0d exp=00000080/3", RegWriteData_wb, RegWriteAddr_wb); end
      checks++; if (RegWrite_wb !== 1'b0 || err_wb !== 2'b00) begin failures++; $display("FAIL st_done_flags got=%b/%b exp=0/00", RegWrite_wb, err_wb); end
   endtask

   task automatic test_timeout(input logic ack_last);
      int nreq = 0, nstall = 0;
      drive(0, 1, 1, 5'd9, 32'h100, 32'h0, 1'b0, 32'h55AA);
      for (int i = 0; i < 16; i++) begin
         if (i == 15 && ack_last) drive(0, 1, 1, 5'd9, 32'h100, 32'h0, 1'b1, 32'h55AA);
         nreq += int'(dmem_req);
         nstall += int'(stall_mem);
         if (i < 15) begin
            checks++; if (RegWrite_wb !== 1'b0 || err_wb !== 2'b00) begin failures++; $display("FAIL tmo_bubble%0d got=%b/%b exp=0/00", i, RegWrite_wb, err_wb); end
         end
         tick;
      end
      checks++; if (nreq !== 16) begin failures++; $display("FAIL tmo_req_cycles got=%0d exp=16", nreq); end
      checks++; if (nstall !== 15) begin failures++; $display("FAIL tmo_stall_cycles got=%0d exp=15", nstall); end
      if (ack_last) begin
         checks++; if (err_wb !== 2'b00 || RegWrite_wb !== 1'b1 || RegWriteData_wb !== 32'h55AA) begin failures++; $display("FAIL tmo_acklast got=%b/%b/%h exp=00/1/000055aa", err_wb, RegWrite_wb, RegWriteData_wb); end
      end else begin
         checks++; if (err_wb !== 2'b10 || RegWrite_wb !== 1'b0) begin failures++; $display("FAIL tmo_err got=%b/%b exp=10/0", err_wb, RegWrite_wb); end
      end
      drive(0, 0, 0, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0);
      tick;
      checks++; if (err_wb !== 2'b00) begin failures++; $display("FAIL tmo_pulse got=%b exp=00", err_wb); end
   endtask

   task automatic test_reset_mid_wait;
      drive(0, 0, 1, 5'd7, 32'h99, 32'h0, 1'b0, 32'h0);
      tick;
      drive(0, 1, 1, 5'd8, 32'h200, 32'h0, 1'b0, 32'h0);
      tick;
      tick;
      reset = 1'b1;
      #1;
      for (int i = 0; i < 2; i++) begin
         checks++; if (dmem_req !== 1'b0 || stall_mem !== 1'b0) begin failures++; $display("FAIL rst_outputs%0d got=%b/%b exp=0/0", i, dmem_req, stall_mem); end
         tick;
      end
      reset = 1'b0;
      test_reset_state;
   endtask

   task automatic test_misaligned;
      drive(0, 1, 1, 5'd4, 32'h42, 32'h0, 1'b0, 32'h0);
      checks++; if (dmem_req !== 1'b0 || stall_mem !== 1'b0) begin failures++; $display("FAIL mis_req got=%b/%b exp=0/0", dmem_req, stall_mem); end
      tick;
      checks++; if (err_wb !== 2'b01 || RegWrite_wb !== 1'b0) begin failures++; $display("FAIL mis_err got=%b/%b exp=01/0", err_wb, RegWrite_wb); end
      drive(1, 0, 0, 5'd0, 32'h81, 32'h1, 1'b1, 32'h0);
      checks++; if (dmem_req !== 1'b0) begin failures++; $display("FAIL mis_st_req got=%b exp=0", dmem_req); end
      tick;
      checks++; if (err_wb !== 2'b01) begin failures++; $display("FAIL mis_st_err got=%b exp=01", err_wb); end
   endtask

   task automatic test_back_to_back;
      drive(0, 1, 1, 5'd8, 32'h44, 32'h0, 1'b0, 32'h0);
      tick;
      drive(0, 1, 1, 5'd8, 32'h44, 32'h0, 1'b1, 32'h11111111);
      tick;
      checks++; if (RegWriteData_wb !== 32'h11111111 || RegWriteAddr_wb !== 5'd8) begin failures++; $display("FAIL b2b_first got=%h/%0d exp=11111111/8", RegWriteData_wb, RegWriteAddr_wb); end
      drive(0, 1, 1, 5'd9, 32'h48, 32'h0, 1'b1, 32'h22222222);
      checks++; if (dmem_req !== 1'b1 || stall_mem !== 1'b0) begin failures++; $display("FAIL b2b_req got=%b/%b exp=1/0", dmem_req, stall_mem); end
      tick;
      checks++; if (RegWriteData_wb !== 32'h22222222 || RegWriteAddr_wb !== 5'd9) begin failures++; $display("FAIL b2b_second got=%h/%0d exp=22222222/9", RegWriteData_wb, RegWriteAddr_wb); end
   endtask

   initial begin
      reset = 1'b1;
      drive(0, 0, 0, 5'd0, 32'h0, 32'h0, 1'b0, 32'h0);
      tick;
      tick;
      reset = 1'b0;
      test_reset_state;
      test_alu;
      test_load_zero_wait;
      test_store_wait3;
      test_reset_mid_wait;
      test_timeout(1'b0);
      test_timeout(1'b1);
      test_misaligned;
      test_back_to_back;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
